// File: rtl/valid_ready_burst_source_pkg.sv
// valid_ready_burst_source_pkg
// Shared types and constants for the valid/ready burst source:
//   - state_t        : burst FSM encoding (IDLE, SEND, GAP)
//   - PATTERN        : 16-entry 4-bit pattern table, entry i at bits [4*i +: 4]
//   - LFSR_SEED/TAPS : seed and feedback taps of the x^4+x^3+1 Fibonacci LFSR
//   - pattern_word() : table lookup
//   - lfsr_next()    : one LFSR step
// The LFSR constants are only consumed when VALID_READY_BURST_SOURCE_LFSR_EN
// is defined.
package valid_ready_burst_source_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Reads from the LSB nibble upward: 2,6,d,b,7,e,c,4,1,0,9,a,f,5,8,3
    localparam logic [63:0] PATTERN = 64'h385f_a901_4ce7_bd62;

    localparam logic [3:0] LFSR_SEED = 4'h1;
    // Feedback is the XOR of s[3] and s[2]
    localparam logic [3:0] LFSR_TAPS = 4'b1100;

    function automatic logic [3:0] pattern_word(input logic [3:0] idx);
        return PATTERN[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/valid_ready_burst_source_lfsr4.sv
// burst_source_lfsr4
// 4-bit Fibonacci LFSR (x^4+x^3+1) used as the pattern generator when
// VALID_READY_BURST_SOURCE_LFSR_EN is defined; the module only exists in that
// build. Period 15, never reaches 0.
// Ports:
//   clk     in  1  clock, rising edge
//   rst     in  1  asynchronous reset, active-low (loads LFSR_SEED)
//   advance in  1  step the LFSR on this edge
//   value   out 4  current LFSR state
`ifdef VALID_READY_BURST_SOURCE_LFSR_EN
module burst_source_lfsr4
    import valid_ready_burst_source_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [3:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule
`endif

// File: rtl/valid_ready_burst_source.sv
// valid_ready_burst_source
// Valid/ready stream source emitting a fixed 4-bit pseudo-random pattern in
// bursts of burst_len beats separated by gap_len idle cycles. up_valid and
// up_data are register outputs and are held until the beat is accepted.
// Build option: VALID_READY_BURST_SOURCE_LFSR_EN selects an LFSR pattern
// generator instead of the 16-entry table.
// Parameters:
//   width    data width (>= 4); pattern words are zero-extended
//   w_count  width of beat_count
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active-low
//   enable     in   1        run request
//   burst_len  in   4        beats per burst, 0 = continuous
//   gap_len    in   4        idle cycles between bursts, 0 = none
//   up_valid   out  1        data offered
//   up_ready   in   1        consumer accepts
//   up_data    out  width    current pattern word
//   beat_count out  w_count  completed handshakes, wraps
//   busy       out  1        FSM not in IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing offered; waits for enable, then latches the lengths
// SEND  | up_valid=1; counts accepted beats against the latched burst_len
// GAP   | up_valid=0 for exactly the latched gap_len cycles
module valid_ready_burst_source
    import valid_ready_burst_source_pkg::*;
#(
    parameter int width   = 4,
    parameter int w_count = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [3:0]         burst_len,
    input  logic [3:0]         gap_len,
    output logic               up_valid,
    input  logic               up_ready,
    output logic [width-1:0]   up_data,
    output logic [w_count-1:0] beat_count,
    output logic               busy
);

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         burst_len_q;
    logic [3:0]         gap_len_q;
    logic [3:0]         beat_in_burst_q;
    logic [3:0]         gap_cnt_q;
    logic [w_count-1:0] beat_count_q;
    logic [3:0]         word;

    logic transfer;
    logic burst_end;
    logic latch_len;
    logic clr_beat;
    logic load_gap;

    assign transfer  = up_valid & up_ready;
    assign burst_end = (beat_in_burst_q + 4'd1) == burst_len_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        latch_len = 1'b0;
        clr_beat  = 1'b0;
        load_gap  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = SEND;
                    latch_len = 1'b1;
                    clr_beat  = 1'b1;
                end
            end
            SEND: begin
                // Without a transfer the offered beat must stay, so enable is ignored
                if (transfer) begin
                    if (burst_len_q != 4'd0 && burst_end) begin
                        if (gap_len_q != 4'd0) begin
                            state_d  = GAP;
                            load_gap = 1'b1;
                        end else if (enable) begin
                            latch_len = 1'b1;
                            clr_beat  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (!enable) begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd1) begin
                    if (enable) begin
                        state_d   = SEND;
                        latch_len = 1'b1;
                        clr_beat  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        up_valid = (state_q == SEND);
        busy     = (state_q != IDLE);
    end

    // Burst/gap bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_len_q     <= 4'd0;
            gap_len_q       <= 4'd0;
            beat_in_burst_q <= 4'd0;
            gap_cnt_q       <= 4'd0;
            beat_count_q    <= '0;
        end else begin
            if (latch_len) begin
                burst_len_q <= burst_len;
                gap_len_q   <= gap_len;
            end
            // Clear wins over increment when a gapless burst rolls over
            if (clr_beat) begin
                beat_in_burst_q <= 4'd0;
            end else if (transfer) begin
                beat_in_burst_q <= beat_in_burst_q + 4'd1;
            end
            if (load_gap) begin
                gap_cnt_q <= gap_len_q;
            end else if (state_q == GAP) begin
                gap_cnt_q <= gap_cnt_q - 4'd1;
            end
            if (transfer) begin
                beat_count_q <= beat_count_q + w_count'(1);
            end
        end
    end

`ifdef VALID_READY_BURST_SOURCE_LFSR_EN
    burst_source_lfsr4 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (transfer),
        .value   (word)
    );
`else
    logic [3:0] index_q;
    logic [3:0] word_q;

    // The word register is loaded with the entry for the next index so the
    // output stays a pure flop rather than a table lookup after the index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q <= 4'd0;
            word_q  <= pattern_word(4'd0);
        end else if (transfer) begin
            index_q <= index_q + 4'd1;
            word_q  <= pattern_word(index_q + 4'd1);
        end
    end

    assign word = word_q;
`endif

    always_comb begin
        up_data      = '0;
        up_data[3:0] = word;
    end

    assign beat_count = beat_count_q;

endmodule
